chan_scan_mux: RTL and testbench

//  Parametrised N-channel, W-bit registered selector with valid/ready output.

---
 rtl/chan_scan_mux_if.sv | 27 ++
 rtl/chan_scan_mux.sv | 79 +++++++
 tb/tb_chan_scan_mux.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/chan_scan_mux_if.sv
// chan_scan_mux_if: channel inputs, scan controls and valid/ready sample output of chan_scan_mux
interface chan_scan_mux_if #(
  parameter int N_CH    = 16,
  parameter int DW      = 8,
  parameter int SELW    = $clog2(N_CH),
  parameter int DWELL_W = 16
);
  logic [N_CH*DW-1:0] x_flat;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [N_CH-1:0]    en_mask;
  logic [DWELL_W-1:0] dwell;
  logic               start;
  logic [DW-1:0]      y;
  logic [SELW-1:0]    y_ch;
  logic               y_valid;
  logic               y_ready;
  logic               busy;
  modport master (
    output x_flat, mode, sel, en_mask, dwell, start, y_ready,
    input  y, y_ch, y_valid, busy
  );
  modport slave (
    input  x_flat, mode, sel, en_mask, dwell, start, y_ready,
    output y, y_ch, y_valid, busy
  );
endinterface

// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered N-channel selector with manual select and round-robin dwell scan
module chan_scan_mux #(
  parameter int N_CH    = 16,
  parameter int DW      = 8,
  parameter int SELW    = $clog2(N_CH),
  parameter int DWELL_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  chan_scan_mux_if.slave  bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DWELL = 2'd1;
  localparam logic [1:0] EMIT  = 2'd2;

  logic [1:0]         state;
  logic [SELW-1:0]    cur, first, nxt, sel_c, ld_ch;
  logic [DWELL_W-1:0] cnt;
  logic               free, ld;
  logic [DW-1:0]      xs;

  assign free      = !bus.y_valid || bus.y_ready;
  assign sel_c     = (int'(bus.sel) >= N_CH) ? SELW'(N_CH - 1) : bus.sel;
  assign ld        = (state == IDLE && !bus.mode) || state == EMIT;
  assign ld_ch     = (state == EMIT) ? cur : sel_c;
  assign xs        = bus.x_flat[int'(ld_ch)*DW +: DW];
  assign bus.busy  = state != IDLE;

  // lowest enabled channel, and next enabled channel after cur (wrapping, may be cur itself)
  always_comb begin
    first = '0;
    nxt   = cur;
    for (int i = N_CH - 1; i >= 0; i--)
      if (bus.en_mask[i]) first = SELW'(i);
    for (int i = N_CH; i >= 1; i--)
      if (bus.en_mask[(int'(cur) + i) % N_CH]) nxt = SELW'((int'(cur) + i) % N_CH);
  end

  // output slot and scan FSM; the FSM stalls in EMIT rather than overwrite an unaccepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur         <= '0;
      cnt         <= '0;
      bus.y       <= '0;
      bus.y_ch    <= '0;
      bus.y_valid <= 1'b0;
    end else begin
      if (free) begin
        bus.y_valid <= ld;
        if (ld) begin
          bus.y    <= xs;
          bus.y_ch <= ld_ch;
        end
      end
      case (state)
        IDLE:
          if (bus.mode && bus.start && |bus.en_mask) begin
            cur   <= first;
            cnt   <= bus.dwell;
            state <= DWELL;
          end
        DWELL:
          if (cnt != '0) cnt <= cnt - DWELL_W'(1);
          else state <= EMIT;
        EMIT:
          if (free) begin
            cur <= nxt;
            if (!bus.mode || ~|bus.en_mask) state <= IDLE;
            else begin
              cnt   <= bus.dwell;
              state <= DWELL;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: directed checks of manual select, clamp, auto scan, stall, empty mask and async reset
module tb_chan_scan_mux;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  chan_scan_mux_if #(.N_CH(16), .DW(8)) bus ();
  chan_scan_mux_if #(.N_CH(12), .DW(8)) bus12 ();

  chan_scan_mux #(.N_CH(16), .DW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  chan_scan_mux #(.N_CH(12), .DW(8)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (bus.busy !== 1'b0) $display("FAIL %s idle timeout: busy=%b want 0", name, bus.busy);
    else passed++;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 16; k++) bus.x_flat[k*8 +: 8] = 8'(8'hA0 + k);
    for (int k = 0; k < 12; k++) bus12.x_flat[k*8 +: 8] = 8'(8'h50 + k);
    bus.mode = 1'b1; bus.sel = '0; bus.en_mask = '0; bus.dwell = '0; bus.start = 1'b0; bus.y_ready = 1'b1;
    bus12.mode = 1'b1; bus12.sel = '0; bus12.en_mask = '0; bus12.dwell = '0; bus12.start = 1'b0; bus12.y_ready = 1'b1;
    #1 rst = 1'b1;
    tick();
    tick();
    total++;
    if (bus.y !== 8'h00 || bus.y_ch !== 4'd0 || bus.y_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL reset: y=%h y_ch=%0d v=%b busy=%b want 00 0 0 0", bus.y, bus.y_ch, bus.y_valid, bus.busy);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_manual;
    bus.mode = 1'b0;
    bus.y_ready = 1'b1;
    for (int s = 0; s < 16; s++) begin
      bus.sel = 4'(s);
      tick();
      total++;
      if (bus.y !== 8'(8'hA0 + s) || bus.y_ch !== 4'(s) || bus.y_valid !== 1'b1)
        $display("FAIL manual sel=%0d: y=%h y_ch=%0d v=%b want y=%h y_ch=%0d v=1",
                 s, bus.y, bus.y_ch, bus.y_valid, 8'(8'hA0 + s), s);
      else passed++;
    end
  endtask

  task automatic test_clamp;
    logic [3:0] sels [3] = '{4'd15, 4'd12, 4'd5};
    logic [3:0] chs  [3] = '{4'd11, 4'd11, 4'd5};
    bus12.mode = 1'b0;
    bus12.y_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus12.sel = sels[i];
      tick();
      total++;
      if (bus12.y !== 8'(8'h50 + chs[i]) || bus12.y_ch !== chs[i] || bus12.y_valid !== 1'b1)
        $display("FAIL clamp sel=%0d: y=%h y_ch=%0d v=%b want y=%h y_ch=%0d v=1",
                 sels[i], bus12.y, bus12.y_ch, bus12.y_valid, 8'(8'h50 + chs[i]), chs[i]);
      else passed++;
    end
  endtask

  task automatic test_auto_scan;
    logic [3:0] seq [4] = '{4'd0, 4'd2, 4'd8, 4'd0};
    logic       ev;
    logic [3:0] ec;
    bus.mode = 1'b1; bus.en_mask = 16'h0105; bus.dwell = 16'd3; bus.y_ready = 1'b1;
    tick();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) $display("FAIL scan start: busy=%b want 1", bus.busy);
    else passed++;
    for (int i = 1; i <= 20; i++) begin
      tick();
      ev = (i % 5 == 0);
      ec = ev ? seq[i/5 - 1] : 4'd0;
      total++;
      if (bus.y_valid !== ev || (ev && (bus.y_ch !== ec || bus.y !== 8'(8'hA0 + ec))))
        $display("FAIL scan cycle %0d: v=%b y_ch=%0d y=%h want v=%b y_ch=%0d y=%h",
                 i, bus.y_valid, bus.y_ch, bus.y, ev, ec, 8'(8'hA0 + ec));
      else passed++;
    end
    bus.mode = 1'b0;
    wait_idle("scan");
  endtask

  task automatic test_stall;
    logic found = 1'b0;
    bus.mode = 1'b1; bus.en_mask = 16'h0003; bus.dwell = 16'd0; bus.y_ready = 1'b1;
    tick();
    tick();
    bus.y_ready = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i >= 2) begin
        total++;
        if (bus.y_valid !== 1'b1 || bus.y_ch !== 4'd0 || bus.y !== 8'hA0)
          $display("FAIL stall cycle %0d: v=%b y_ch=%0d y=%h want v=1 y_ch=0 y=a0", i, bus.y_valid, bus.y_ch, bus.y);
        else passed++;
      end
    end
    bus.y_ready = 1'b1;
    for (int j = 0; j < 2 && !found; j++) begin
      tick();
      found = bus.y_valid && bus.y_ch == 4'd1 && bus.y == 8'hA1;
    end
    total++;
    if (!found) $display("FAIL stall release: v=%b y_ch=%0d y=%h want v=1 y_ch=1 y=a1", bus.y_valid, bus.y_ch, bus.y);
    else passed++;
    bus.mode = 1'b0;
    wait_idle("stall");
  endtask

  task automatic test_empty_mask;
    bus.mode = 1'b1; bus.en_mask = 16'h0000; bus.dwell = 16'd2; bus.y_ready = 1'b1;
    tick();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.busy !== 1'b0 || bus.y_valid !== 1'b0)
        $display("FAIL empty mask cycle %0d: busy=%b v=%b want 0 0", i, bus.busy, bus.y_valid);
      else passed++;
      tick();
    end
  endtask

  task automatic test_reset_mid_scan;
    bus.mode = 1'b1; bus.en_mask = 16'h0105; bus.dwell = 16'd3; bus.y_ready = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (bus.busy !== 1'b1 || bus.y_valid !== 1'b1 || bus.y !== 8'hA0)
      $display("FAIL pre-reset: busy=%b v=%b y=%h want 1 1 a0", bus.busy, bus.y_valid, bus.y);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.y !== 8'h00 || bus.y_ch !== 4'd0 || bus.y_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL async reset: y=%h y_ch=%0d v=%b busy=%b want 00 0 0 0", bus.y, bus.y_ch, bus.y_valid, bus.busy);
    else passed++;
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.y_valid !== 1'b0)
      $display("FAIL post-reset: busy=%b v=%b want 0 0", bus.busy, bus.y_valid);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_clamp();
    test_auto_scan();
    test_stall();
    test_empty_mask();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
